// File: rtl/chip8_ram_loader.sv
// chip8_ram_loader: Chip-8 dual-port RAM (CPU on port A, video on port B) with a clear-and-load program loader.
// Latency: 1-cycle reads on both ports; a load clears DEPTH-LOAD_BASE words, then accepts 1 byte/cycle.
// Backpressure: ld_ready only while loading; CPU port ignored while o_a_busy. Macro CHIP8_FONT_PROTECT_EN makes the font read-only to the CPU.
module chip8_ram_loader #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int LOAD_BASE = 'h200,
  parameter int FONT_END  = 'h120
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_en,
  input  logic              i_a_write,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_in,
  output logic [DATA_W-1:0] o_a_out,
  output logic              o_a_busy,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [DATA_W-1:0] o_b_out,
  input  logic              i_ld_start,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_last,
  output logic              o_ld_ready,
  output logic              o_ld_done,
  output logic [ADDR_W-1:0] o_ld_count,
  output logic              o_ld_trunc
);

  localparam int DEPTH      = 2**ADDR_W;
  localparam int FONT_BYTES = 288;
  localparam int FB_AW      = $clog2(FONT_BYTES*8);
  localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] PTR_TOP  = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] FONT_TOP = ADDR_W'(FONT_END);

`ifdef CHIP8_FONT_PROTECT_EN
  localparam logic FONT_RO = 1'b1;
`else
  localparam logic FONT_RO = 1'b0;
`endif

  // Font images (font_small.vh at 0x000, font_large.vh at 0x080), listed in address order.
  localparam logic [FONT_BYTES*8-1:0] FONT_IMG = {
    40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
    40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
    40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
    40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080,
    384'h0,
    80'hFFFFC3C3C3C3C3C3FFFF, 80'h1878781818181818FFFF, 80'hFFFF0303FFFFC0C0FFFF,
    80'hFFFF0303FFFF0303FFFF, 80'hC3C3C3C3FFFF03030303, 80'hFFFFC0C0FFFF0303FFFF,
    80'hFFFFC0C0FFFFC3C3FFFF, 80'hFFFF0303060C18181818, 80'hFFFFC3C3FFFFC3C3FFFF,
    80'hFFFFC3C3FFFF0303FFFF, 80'h7EFFC3C3C3FFFFC3C3C3, 80'hFCFCC3C3FCFCC3C3FCFC,
    80'h3CFFC3C0C0C0C0C3FF3C, 80'hFCFEC3C3C3C3C3C3FEFC, 80'hFFFFC0C0FFFFC0C0FFFF,
    80'hFFFFC0C0FFFFC0C0C0C0
  };

  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_t;

  function automatic mem_t f_mem_init();
    mem_t m;
    m = '0;
    for (int i = 0; i < FONT_BYTES; i++)
      m[ADDR_W'(i)] = DATA_W'(FONT_IMG[FB_AW'((FONT_BYTES-1-i)*8) +: 8]);
    return m;
  endfunction

  // Power-up image: fonts at the bottom, zeros elsewhere; never touched by reset.
  mem_t r_mem = f_mem_init();

  state_t            r_state, w_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_trunc;
  logic [DATA_W-1:0] r_a_out, r_b_out;
  logic              w_busy, w_ready, w_done, w_acc, w_cpu_wr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_wa;
  logic [DATA_W-1:0] w_mem_wd;

  assign w_acc    = i_ld_valid && (r_state == S_LOAD);
  assign w_cpu_wr = i_a_en && i_a_write && !(FONT_RO && (i_a_addr < FONT_TOP));

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  // Next state, handshake outputs and the single RAM write port (CPU in IDLE, loader otherwise).
  always_comb begin
    w_nxt    = r_state;
    w_busy   = 1'b1;
    w_ready  = 1'b0;
    w_done   = 1'b0;
    w_mem_we = 1'b0;
    w_mem_wa = r_ptr;
    w_mem_wd = '0;
    case (r_state)
      S_IDLE: begin
        w_busy   = 1'b0;
        w_mem_we = w_cpu_wr;
        w_mem_wa = i_a_addr;
        w_mem_wd = i_a_in;
        if (i_ld_start) w_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_mem_we = 1'b1;
        if (r_ptr == PTR_TOP) w_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (w_acc) begin
          w_mem_we = 1'b1;
          w_mem_wd = i_ld_data;
          if (i_ld_last || (r_ptr == PTR_TOP)) w_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_nxt  = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Loader pointer, byte count and truncation flag; count/trunc hold until the next start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr   <= PTR_BASE;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_ld_start) begin
          r_ptr   <= PTR_BASE;
          r_cnt   <= '0;
          r_trunc <= 1'b0;
        end
        S_CLEAR: r_ptr <= (r_ptr == PTR_TOP) ? PTR_BASE : r_ptr + 1'b1;
        S_LOAD: if (w_acc) begin
          r_ptr <= r_ptr + 1'b1;
          r_cnt <= r_cnt + 1'b1;
          if ((r_ptr == PTR_TOP) && !i_ld_last) r_trunc <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // RAM write; a reset edge suppresses any in-flight loader write.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_mem_we) r_mem[w_mem_wa] <= w_mem_wd;
  end

  // Registered reads (old data on same-cycle writes); port A holds while the loader owns it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a_out <= '0;
      r_b_out <= '0;
    end else begin
      r_b_out <= r_mem[i_b_addr];
      if (!w_busy && i_a_en) r_a_out <= r_mem[i_a_addr];
    end
  end

  assign o_a_out    = r_a_out;
  assign o_b_out    = r_b_out;
  assign o_a_busy   = w_busy;
  assign o_ld_ready = w_ready;
  assign o_ld_done  = w_done;
  assign o_ld_count = r_cnt;
  assign o_ld_trunc = r_trunc;

endmodule

// File: doc/chip8_ram_loader.md
# chip8_ram_loader

Parametrised successor to the Chip-8 CPU dual-port memory. Adds a synchronous reset, a handshake-driven program loader that clears and refills the program region while the CPU is held off, and optional write protection of the font region. CPU accesses use port A, the video scanout uses port B, and an external ROM source (UART or SPI flash reader) drives the loader stream.

## Interface
Parameters:
- DATA_W, 8, RAM word width
- ADDR_W, 12, address width; DEPTH = 2**ADDR_W
- LOAD_BASE, 'h200, first program address; the clear and load operations start here
- FONT_END, 'h120, first address above the font images (small font 0x000–0x07F, large font 0x080–0x11F, preloaded from font_small.vh and font_large.vh)

Ports:
- clk  in  1  single clock for all ports
- rst_n  in  1  synchronous, active-low reset
- a_en  in  1  CPU access enable
- a_write  in  1  CPU write when a_en=1
- a_addr  in  ADDR_W  CPU address
- a_in  in  DATA_W  CPU write data
- a_out  out  DATA_W  CPU read data
- a_busy  out  1  loader owns port A; CPU accesses are ignored
- b_addr  in  ADDR_W  video read address
- b_out  out  DATA_W  video read data
- ld_start  in  1  pulse: begin clear and load
- ld_valid  in  1  loader byte valid
- ld_data  in  DATA_W  loader byte
- ld_last  in  1  final byte of image, qualified by ld_valid
- ld_ready  out  1  loader accepts a byte this cycle
- ld_done  out  1  one-cycle pulse at end of load
- ld_count  out  ADDR_W  bytes written by the last load
- ld_trunc  out  1  last load hit the top of memory before ld_last

## Operation
- FSM states are IDLE, CLEAR, LOAD and DONE. The reset state is IDLE.
- IDLE: a_busy=0 and the CPU has port A.
  - ld_start=1 moves to CLEAR and sets ptr=LOAD_BASE.
  - A CPU access in the same cycle as ld_start is still served.
- CLEAR: a_busy=1. Each cycle writes 0 to ram[ptr] and increments ptr.
  - After the write at DEPTH-1: ptr returns to LOAD_BASE and the FSM moves to LOAD.
  - CLEAR lasts DEPTH-LOAD_BASE cycles (3584 with the defaults).
- LOAD: a_busy=1 and ld_ready=1.
  - Each cycle with ld_valid&&ld_ready writes ld_data to ram[ptr], then increments ptr and the count.
  - An accepted byte with ld_last=1 moves to DONE.
  - An accepted byte at ptr=DEPTH-1 without ld_last also moves to DONE and sets ld_trunc=1.
- DONE: lasts one cycle.
  - ld_done=1, ld_ready=0, a_busy=1.
  - ld_count is latched, the FSM returns to IDLE and a_busy drops the next cycle.
- ld_count and ld_trunc hold until the next ld_start. Both clear on entry to CLEAR.
- ld_start outside IDLE is ignored.
- CPU write semantics:
  - Port A writes are read-before-write: a_out returns the old contents.
  - While a_busy=1, a_out holds its last value and writes are dropped.
- Port B reads every cycle regardless of FSM state.
  - A same-address write on port A in the same cycle returns the old data on b_out.
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - a_out, b_out, ld_count = 0; a_busy, ld_ready, ld_done, ld_trunc = 0.
  - RAM contents are not reset.
  - A reset during CLEAR or LOAD aborts the operation, keeps the partial contents, and produces no ld_done.

## Timing
- Read latency on both ports is one cycle: address at edge N, data valid after edge N+1.
- a_busy rises the cycle after ld_start is sampled.
- ld_ready first rises DEPTH-LOAD_BASE cycles after a_busy rises.
- Loader throughput is one byte per cycle with ld_valid held high.
- ld_done is asserted in the cycle after the final byte is accepted.
- a_busy falls one cycle after ld_done.

## Configuration
- CHIP8_FONT_PROTECT_EN defined:
  - CPU writes with a_addr < FONT_END are dropped silently.
  - a_out still returns the stored (old) value.
- CHIP8_FONT_PROTECT_EN undefined: all CPU addresses are writable.
- The loader is unaffected in both cases, since it never writes below LOAD_BASE.

## Test plan
- Reset then font read: port B at 0x000 reads the first font_small byte one cycle later; a_out=0 after reset.
- CPU write 0x5A at 0x300, read 0x300 on the next cycle: a_out=0x5A; the write-cycle a_out shows the old value.
- Load 4 bytes 11,22,33,44 with ld_last on the 4th:
  - 0x200–0x203 hold the data and 0x204–0xFFF read 0.
  - ld_done pulses once; ld_count=4; ld_trunc=0.
- Stall ld_valid for 5 cycles mid-load: no writes occur, ptr is unchanged, and the final image is contiguous.
- Stream 3600 bytes without ld_last: the load stops after 3584 bytes, with ld_trunc=1 and ld_count=3584.
- With CHIP8_FONT_PROTECT_EN, write 0xFF at 0x010: a read returns the font byte. Without the macro it returns 0xFF. Separately, asserting rst_n=0 mid-LOAD drops a_busy with no ld_done.
